// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the IF/ID register payload type.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            pred_taken;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   bubble,
  input  logic   hold,
  input  if_id_t load_data,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q.instr      <= NOP_INSTR;
      q.pc         <= '0;
      q.pc_plus4   <= '0;
      q.pred_taken <= 1'b0;
      q.valid      <= 1'b0;
    end else if (bubble) begin
      // PC fields are left as-is; only the instruction payload is squashed.
      q.instr      <= NOP_INSTR;
      q.pred_taken <= 1'b0;
      q.valid      <= 1'b0;
    end else if (!hold) begin
      q <= load_data;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection, IF/ID register and perf counters.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned           CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCBPUSrc,
  input  logic [DATA_WIDTH-1:0] PCBPU,
  input  logic                  flushBranch,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic [DATA_WIDTH-1:0] RD,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  PredTakenD,
  output logic                  ValidD,
  output logic [CNT_WIDTH-1:0]  FetchCount,
  output logic [CNT_WIDTH-1:0]  RedirectCount
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_plus4;
  logic [CNT_WIDTH-1:0]  fetch_cnt_q, redirect_cnt_q;
  logic                  redirect, bubble, load;
  if_id_t                if_id_d, if_id_q;

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);
  assign redirect = flushBranch | PCSrcE;
  assign bubble   = redirect | FlushD;
  assign load     = !bubble && !StallD;

  always_comb begin
    pc_d = pc_plus4;
    if (flushBranch) begin
      pc_d = {PCBPU[DATA_WIDTH-1:2], 2'b00};
    end else if (PCSrcE) begin
      pc_d = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
    end else if (StallF) begin
      pc_d = pc_q;
    end else if (PCBPUSrc) begin
      pc_d = {PCBPU[DATA_WIDTH-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (load) fetch_cnt_q <= fetch_cnt_q + CNT_WIDTH'(1);
      if (redirect) redirect_cnt_q <= redirect_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    if_id_d.instr      = RD;
    if_id_d.pc         = pc_q;
    if_id_d.pc_plus4   = pc_plus4;
    if_id_d.pred_taken = PCBPUSrc;
    if_id_d.valid      = 1'b1;
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .bubble    (bubble),
    .hold      (StallD),
    .load_data (if_id_d),
    .q         (if_id_q)
  );

  assign PCF           = pc_q;
  assign InstrD        = if_id_q.instr;
  assign PCD           = if_id_q.pc;
  assign PCPlus4D      = if_id_q.pc_plus4;
  assign PredTakenD    = if_id_q.pred_taken;
  assign ValidD        = if_id_q.valid;
  assign FetchCount    = fetch_cnt_q;
  assign RedirectCount = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns PCF ^ 32'hABC0_0000.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCBPUSrc, flushBranch, PCSrcE;
  logic [31:0] PCBPU, PCTargetE, RD;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        PredTakenD, ValidD;
  logic [31:0] FetchCount, RedirectCount;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign RD = PCF ^ 32'hABC0_0000;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .StallF        (StallF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .PCBPUSrc      (PCBPUSrc),
    .PCBPU         (PCBPU),
    .flushBranch   (flushBranch),
    .PCSrcE        (PCSrcE),
    .PCTargetE     (PCTargetE),
    .RD            (RD),
    .PCF           (PCF),
    .InstrD        (InstrD),
    .PCD           (PCD),
    .PCPlus4D      (PCPlus4D),
    .PredTakenD    (PredTakenD),
    .ValidD        (ValidD),
    .FetchCount    (FetchCount),
    .RedirectCount (RedirectCount)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    StallF = 0; StallD = 0; FlushD = 0; PCBPUSrc = 0; flushBranch = 0; PCSrcE = 0;
    PCBPU = '0; PCTargetE = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    step();
    step();
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_instr", InstrD, 32'h13);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pcp4", PCPlus4D, 32'h0);
    chk("rst_valid", {31'b0, ValidD}, 32'h0);
    chk("rst_pred", {31'b0, PredTakenD}, 32'h0);
    chk("rst_fc", FetchCount, 32'h0);
    chk("rst_rc", RedirectCount, 32'h0);

    // Free run
    rst = 0;
    step();
    chk("run1_pcf", PCF, 32'h4);
    chk("run1_instr", InstrD, 32'hABC0_0000);
    chk("run1_pcd", PCD, 32'h0);
    chk("run1_pcp4", PCPlus4D, 32'h4);
    chk("run1_valid", {31'b0, ValidD}, 32'h1);
    chk("run1_fc", FetchCount, 32'h1);
    step();
    chk("run2_pcf", PCF, 32'h8);
    chk("run2_pcd", PCD, 32'h4);
    chk("run2_fc", FetchCount, 32'h2);

    // Predicted-taken redirect at PCF=8
    PCBPUSrc = 1; PCBPU = 32'h40;
    step();
    chk("pred_pcf", PCF, 32'h40);
    chk("pred_pcd", PCD, 32'h8);
    chk("pred_instr", InstrD, 32'hABC0_0008);
    chk("pred_taken", {31'b0, PredTakenD}, 32'h1);
    chk("pred_fc", FetchCount, 32'h3);
    clear_inputs();

    // Mispredict repair overrides both stalls
    flushBranch = 1; PCBPU = 32'hC; StallF = 1; StallD = 1;
    step();
    chk("fb_pcf", PCF, 32'hC);
    chk("fb_valid", {31'b0, ValidD}, 32'h0);
    chk("fb_instr", InstrD, 32'h13);
    chk("fb_pred", {31'b0, PredTakenD}, 32'h0);
    chk("fb_rc", RedirectCount, 32'h1);
    chk("fb_fc", FetchCount, 32'h3);
    clear_inputs();
    step();
    chk("fb_resume_pcf", PCF, 32'h10);
    chk("fb_resume_instr", InstrD, 32'hABC0_000C);
    chk("fb_resume_pcd", PCD, 32'hC);
    chk("fb_resume_valid", {31'b0, ValidD}, 32'h1);
    chk("fb_resume_fc", FetchCount, 32'h4);

    // Execute jump with misaligned target
    PCSrcE = 1; PCTargetE = 32'h103;
    step();
    chk("jmp_pcf", PCF, 32'h100);
    chk("jmp_valid", {31'b0, ValidD}, 32'h0);
    chk("jmp_instr", InstrD, 32'h13);
    chk("jmp_rc", RedirectCount, 32'h2);
    chk("jmp_fc", FetchCount, 32'h4);

    // flushBranch and PCSrcE together: repair wins, one redirect counted
    flushBranch = 1; PCBPU = 32'h201; PCSrcE = 1; PCTargetE = 32'h300;
    step();
    chk("both_pcf", PCF, 32'h200);
    chk("both_rc", RedirectCount, 32'h3);
    clear_inputs();
    step();
    chk("both_next_pcf", PCF, 32'h204);
    chk("both_next_pcd", PCD, 32'h200);
    chk("both_next_pcp4", PCPlus4D, 32'h204);
    chk("both_next_instr", InstrD, 32'hABC0_0200);
    chk("both_next_fc", FetchCount, 32'h5);

    // Stall for 3 cycles with a pending prediction: stall wins
    StallF = 1; StallD = 1; PCBPUSrc = 1; PCBPU = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pcf", PCF, 32'h204);
      chk("stall_pcd", PCD, 32'h200);
      chk("stall_instr", InstrD, 32'hABC0_0200);
      chk("stall_fc", FetchCount, 32'h5);
    end
    clear_inputs();
    step();
    chk("release_pcf", PCF, 32'h208);
    chk("release_pcd", PCD, 32'h204);
    chk("release_pred", {31'b0, PredTakenD}, 32'h0);
    chk("release_fc", FetchCount, 32'h6);

    // FlushD bubbles without counting a redirect
    FlushD = 1;
    step();
    chk("flushd_pcf", PCF, 32'h20C);
    chk("flushd_valid", {31'b0, ValidD}, 32'h0);
    chk("flushd_fc", FetchCount, 32'h6);
    chk("flushd_rc", RedirectCount, 32'h3);
    clear_inputs();

    // PC wrap
    PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre_pcf", PCF, 32'hFFFF_FFFC);
    chk("wrap_pre_rc", RedirectCount, 32'h4);
    clear_inputs();
    step();
    chk("wrap_pcf", PCF, 32'h0);
    chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PCPlus4D, 32'h0);
    chk("wrap_instr", InstrD, 32'h543F_FFFC);
    chk("wrap_fc", FetchCount, 32'h7);

    // Reset dominates a concurrent repair
    step();
    rst = 1; flushBranch = 1; PCBPU = 32'h40;
    step();
    chk("rstfb_pcf", PCF, 32'h0);
    chk("rstfb_fc", FetchCount, 32'h0);
    chk("rstfb_rc", RedirectCount, 32'h0);
    chk("rstfb_valid", {31'b0, ValidD}, 32'h0);
    chk("rstfb_instr", InstrD, 32'h13);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
